muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand, HI and LO width (even, >= 8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only while idle.
REQ-005 SHALL have port op  input  2  operation: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
REQ-006 SHALL have ports a and b  input  WIDTH  multiplicand/dividend and multiplier/divisor.
REQ-007 SHALL have ports hi_we and lo_we  input  1 each  MTHI/MTLO write strobes.
REQ-008 SHALL have port wdata  input  WIDTH  MTHI/MTLO write data.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports hi and lo  output  WIDTH  architectural HI and LO registers.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and FINISH.
REQ-013 IDLE: start=1 SHALL latch a, b and op, clear the iteration counter, and enter RUN on the same edge; busy=1 from the next cycle.
REQ-014 RUN SHALL do one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for exactly WIDTH cycles, then enter FINISH.
REQ-015 FINISH SHALL write hi/lo, assert done for exactly one cycle with busy=0, and return to IDLE.
REQ-016 done SHALL occur WIDTH+1 cycles after the accepting edge (33 for WIDTH=32); hi/lo SHALL be valid in the done cycle.
REQ-017 Multiply: {hi,lo} SHALL equal the full 2*WIDTH-bit product.
REQ-018 Divide: lo SHALL equal the quotient and hi the remainder; the remainder takes the dividend's sign.
REQ-019 Divide by zero: lo SHALL be all ones and hi SHALL equal a; latency is unchanged.
REQ-020 start while busy SHALL be ignored; there is no queueing.
REQ-021 hi_we/lo_we while busy SHALL be ignored; in IDLE they update hi/lo on the next edge.
REQ-022 If start and hi_we/lo_we occur in the same IDLE cycle, both SHALL be taken; the operation result later overwrites hi/lo.
REQ-023 Signed DIV of most-negative by -1 SHALL give lo = most-negative and hi = 0.
REQ-024 hi/lo SHALL hold their values between writes; no partial result SHALL be visible on hi/lo during RUN.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE with busy=0, done=0, hi=0, lo=0, counter=0, regardless of the edge.
REQ-026 Reset during RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-027 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Configuration
REQ-028 The macro MULDIV_SIGNED_EN defined SHALL enable MULT/DIV: operands are converted to magnitudes and the results sign-corrected in FINISH.
REQ-029 With MULDIV_SIGNED_EN undefined, op[1] SHALL be ignored: MULT behaves as MULTU and DIV as DIVU, and no sign-correction logic is present.

Structure
REQ-030 A shared package muldiv_pkg SHALL hold the op encoding constants, the FSM state typedef and the iteration-counter width ($clog2(WIDTH)+1).
REQ-031 The datapath step (one shift-add or shift-subtract iteration) SHALL be a combinational sub-module muldiv_step; FSM, counter and HI/LO live in muldiv_unit.

Verification
REQ-032 MULTU a=0xFFFFFFFF, b=2 -> done 33 cycles after start, hi=0x00000001, lo=0xFFFFFFFE.
REQ-033 DIVU a=100, b=7 -> lo=14, hi=2; divide by zero with a=0x1234 -> lo=0xFFFFFFFF, hi=0x1234.
REQ-034 With MULDIV_SIGNED_EN: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Without the macro: MULT a=-3, b=5 gives the unsigned product.
REQ-035 Second start at cycle 5 of RUN -> ignored: a single done pulse, and the result is from the first operands.
REQ-036 Idle: hi_we=1, wdata=0xCAFEF00D -> hi=0xCAFEF00D next cycle; the same write during busy -> hi unchanged.
REQ-037 Start MULTU, then rst_n=0 at cycle 10 -> busy, done, hi and lo are 0 immediately; no done pulse follows; a new start after reset completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM state type and the iteration-counter width helper.
package muldiv_pkg;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_DIVU  = 2'b01;
   localparam logic [1:0] OP_MULT  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   localparam int OP_DIV_BIT    = 0;
   localparam int OP_SIGNED_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract
// divide on the {acc_hi, acc_lo} accumulator pair.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div_i,
   input  logic [WIDTH:0]   acc_hi_i,
   input  logic [WIDTH-1:0] acc_lo_i,
   input  logic [WIDTH-1:0] opnd_i,
   output logic [WIDTH:0]   nxt_hi_o,
   output logic [WIDTH-1:0] nxt_lo_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   always_comb begin
      sum      = acc_lo_i[0] ? (acc_hi_i + {1'b0, opnd_i}) : acc_hi_i;
      shifted  = {acc_hi_i[WIDTH-1:0], acc_lo_i[WIDTH-1]};
      trial    = shifted - {1'b0, opnd_i};
      nxt_hi_o = {1'b0, sum[WIDTH:1]};
      nxt_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
      if (is_div_i) begin
         // trial[WIDTH] is the borrow: set means the divisor did not fit
         if (!trial[WIDTH]) begin
            nxt_hi_o = trial;
            nxt_lo_o = {acc_lo_i[WIDTH-2:0], 1'b1};
         end else begin
            nxt_hi_o = shifted;
            nxt_lo_o = {acc_lo_i[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit, WIDTH+1 cycles per operation.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV; otherwise op[1] is ignored.
//
// state     | meaning
// ST_IDLE   | waiting for start; MTHI/MTLO writes accepted
// ST_RUN    | one datapath iteration per cycle, WIDTH cycles
// ST_FINISH | result on hi/lo, done pulse, back to idle
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH:0]     acc_hi_q, acc_hi_d, step_hi;
   logic [WIDTH-1:0]   acc_lo_q, acc_lo_d, step_lo;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               div_q, div_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]   a_mag, b_mag, res_hi, res_lo;
   logic [2*WIDTH-1:0] prod;
   logic               op_div;

   assign op_div = op[OP_DIV_BIT];

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div_i (div_q),
      .acc_hi_i (acc_hi_q),
      .acc_lo_i (acc_lo_q),
      .opnd_i   (opnd_q),
      .nxt_hi_o (step_hi),
      .nxt_lo_o (step_lo)
   );

`ifdef MULDIV_SIGNED_EN
   logic a_neg, b_neg, negm_in, negr_in, negm_q, negr_q;

   assign a_neg   = op[OP_SIGNED_BIT] & a[WIDTH-1];
   assign b_neg   = op[OP_SIGNED_BIT] & b[WIDTH-1];
   assign a_mag   = a_neg ? -a : a;
   assign b_mag   = b_neg ? -b : b;
   // divide-by-zero keeps the all-ones quotient, so no quotient negation there
   assign negm_in = (a_neg ^ b_neg) & ~(op_div & (b == '0));
   assign negr_in = a_neg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         negm_q <= 1'b0;
         negr_q <= 1'b0;
      end else if (state_q == ST_IDLE && start) begin
         negm_q <= negm_in;
         negr_q <= negr_in;
      end
   end

   always_comb begin
      prod = {step_hi[WIDTH-1:0], step_lo};
      if (!div_q && negm_q) prod = -prod;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      if (div_q && negm_q) res_lo = -step_lo;
      if (div_q && negr_q) res_hi = -step_hi[WIDTH-1:0];
   end
`else
   logic unused_op_sign;

   assign unused_op_sign = op[OP_SIGNED_BIT];
   assign a_mag  = a;
   assign b_mag  = b;
   assign prod   = {step_hi[WIDTH-1:0], step_lo};
   assign res_hi = prod[2*WIDTH-1:WIDTH];
   assign res_lo = prod[WIDTH-1:0];
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opnd_d   = opnd_q;
      div_d    = div_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      unique case (state_q)
         ST_IDLE: begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start) begin
               div_d    = op_div;
               acc_hi_d = '0;
               acc_lo_d = op_div ? a_mag : b_mag;
               opnd_d   = op_div ? b_mag : a_mag;
               cnt_d    = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q + CW'(1);
            // result lands on hi/lo at the edge into FINISH, so it is valid with done
            if (cnt_q == LAST) begin
               hi_d    = res_hi;
               lo_d    = res_lo;
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opnd_q   <= '0;
         div_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opnd_q   <= opnd_d;
         div_q    <= div_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_FINISH);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32); expectations follow the
// MULDIV_SIGNED_EN setting of the build.
module tb_muldiv_unit;

   logic        clk, rst_n, start, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] a, b, wdata, hi, lo;
   logic        busy, done;

   int tests  = 0;
   int errors = 0;

`ifdef MULDIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic from the architectural rules.
   function automatic void model(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                                 output logic [31:0] eh, output logic [31:0] el);
      bit     sgn = SIGNED_EN && o[1];
      longint sa, sb, p;
      int     ia, ib;
      if (!o[0]) begin
         if (sgn) begin
            sa = longint'($signed(xa));
            sb = longint'($signed(xb));
            p  = sa * sb;
         end else begin
            p = longint'({32'd0, xa}) * longint'({32'd0, xb});
         end
         {eh, el} = p;
      end else if (xb == 0) begin
         el = 32'hFFFF_FFFF;
         eh = xa;
      end else if (sgn) begin
         if (xa == 32'h8000_0000 && xb == 32'hFFFF_FFFF) begin
            el = 32'h8000_0000;
            eh = 32'h0;
         end else begin
            ia = $signed(xa);
            ib = $signed(xb);
            el = ia / ib;
            eh = ia % ib;
         end
      end else begin
         el = xa / xb;
         eh = xa % xb;
      end
   endfunction

   task automatic wait_done(inout int lat);
      while (!done && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_op(input string nm, input logic [1:0] o, input logic [31:0] xa,
                           input logic [31:0] xb, input logic [31:0] eh, input logic [31:0] el);
      logic [31:0] h0, l0;
      bit          held;
      int          lat;
      @(negedge clk);
      start = 1'b1; op = o; a = xa; b = xb;
      @(negedge clk);
      start = 1'b0;
      lat = 1; h0 = hi; l0 = lo; held = 1'b1;
      chk({nm, "_busy1"}, 64'(busy), 64'd1);
      while (!done && lat < 60) begin
         if (hi !== h0 || lo !== l0) held = 1'b0;
         @(negedge clk);
         lat++;
      end
      chk({nm, "_latency"}, 64'(lat), 64'd33);
      chk({nm, "_hi"}, 64'(hi), 64'(eh));
      chk({nm, "_lo"}, 64'(lo), 64'(el));
      chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
      chk({nm, "_hold_in_run"}, 64'(held), 64'd1);
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, 64'(done), 64'd0);
   endtask

   initial begin
      logic [31:0] eh, el, rh, rl;
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int          dones, dcyc, lat;

      start = 0; op = 0; a = 0; b = 0; hi_we = 0; lo_we = 0; wdata = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      vecs.push_back('{"multu_max_x2", 2'b00, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE});
      vecs.push_back('{"divu_100_7",   2'b01, 32'd100, 32'd7, 32'd2, 32'd14});
      vecs.push_back('{"divu_by_zero", 2'b01, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF});
      vecs.push_back('{"divu_small",   2'b01, 32'd5, 32'd7, 32'd5, 32'd0});
      vecs.push_back('{"multu_zero",   2'b00, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0});
      if (SIGNED_EN) begin
         vecs.push_back('{"mult_m3_5",  2'b10, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
         vecs.push_back('{"div_m7_2",   2'b11, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
         vecs.push_back('{"div_minneg", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000});
         vecs.push_back('{"div_neg_by0",2'b11, -32'sd9, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF});
      end else begin
         vecs.push_back('{"mult_m3_5",  2'b10, -32'sd3, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1});
         vecs.push_back('{"div_m7_2",   2'b11, -32'sd7, 32'd2, 32'h1, 32'h7FFF_FFFC});
         vecs.push_back('{"div_minneg", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0});
         vecs.push_back('{"div_neg_by0",2'b11, -32'sd9, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF});
      end
      for (int i = 0; i < vecs.size(); i++)
         check_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1, 2:    rb = $urandom_range(1, 300);
            3:       rb = -($urandom_range(1, 300));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 9) == 0) ra = $urandom_range(0, 1000);
         model(ro, ra, rb, eh, el);
         check_op($sformatf("rand%0d", i), ro, ra, rb, eh, el);
      end

      // MTHI/MTLO in idle, then ignored while busy
      @(negedge clk);
      hi_we = 1'b1; wdata = 32'hCAFE_F00D;
      @(negedge clk);
      hi_we = 1'b0;
      chk("mthi_idle", 64'(hi), 64'hCAFE_F00D);
      lo_we = 1'b1; wdata = 32'h1357_2468;
      @(negedge clk);
      lo_we = 1'b0;
      chk("mtlo_idle", 64'(lo), 64'h1357_2468);
      start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      hi_we = 1'b0;
      chk("mthi_busy_ignored", 64'(hi), 64'hCAFE_F00D);
      lat = 2;
      wait_done(lat);
      chk("mthi_busy_lat", 64'(lat), 64'd33);
      chk("mthi_busy_res_lo", 64'(lo), 64'd12);
      chk("mthi_busy_res_hi", 64'(hi), 64'd0);

      // start and MTLO in the same idle cycle
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7; lo_we = 1'b1; wdata = 32'h55AA_55AA;
      @(negedge clk);
      start = 1'b0; lo_we = 1'b0;
      chk("start_mtlo_lo_written", 64'(lo), 64'h55AA_55AA);
      chk("start_mtlo_busy", 64'(busy), 64'd1);
      lat = 1;
      wait_done(lat);
      chk("start_mtlo_lat", 64'(lat), 64'd33);
      chk("start_mtlo_res_lo", 64'(lo), 64'd14);
      chk("start_mtlo_res_hi", 64'(hi), 64'd2);

      // second start during RUN is ignored
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      dones = 0; dcyc = 0; rh = 0; rl = 0;
      for (int c = 1; c <= 45; c++) begin
         if (done) begin
            dones++;
            if (dones == 1) begin dcyc = c; rh = hi; rl = lo; end
         end
         start = (c == 5);
         if (c == 5) begin a = 32'd100; b = 32'd100; end
         @(negedge clk);
      end
      start = 1'b0;
      chk("restart_done_count", 64'(dones), 64'd1);
      chk("restart_done_cycle", 64'(dcyc), 64'd33);
      chk("restart_lo", 64'(rl), 64'd63);
      chk("restart_hi", 64'(rh), 64'd0);

      // reset mid-run aborts
      start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c < 10; c++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_run_busy", 64'(busy), 64'd0);
      chk("rst_run_done", 64'(done), 64'd0);
      chk("rst_run_hi", 64'(hi), 64'd0);
      chk("rst_run_lo", 64'(lo), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("rst_run_no_done", 64'(dones), 64'd0);
      check_op("after_reset", 2'b00, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
